// File: rtl/mac_layer_sequencer_if.sv
// Stream and datapath bundle for mac_layer_sequencer.
//   cmd_*    : job command stream from the host (count of activations)
//   in_*     : activation stream from the host/DMA
//   a_in, start_valid_pipeline, start_layering, clear_all : drive top_system
//   valid_pipeline_busy, layering_busy, valid_out, acc_out_2/3 : from top_system
//   res_*    : result beat {acc_out_3, acc_out_2} back to the host
//   busy, err, err_code : status
// master = the sequencer, slave = the surrounding host/datapath.
interface mac_layer_sequencer_if #(
    parameter int ACC_W  = 16,
    parameter int N_MACS = 4,
    parameter int CNT_W  = 4
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [CNT_W-1:0]        cmd_count;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [ACC_W-1:0] in_data;
    logic signed [ACC_W-1:0] a_in;
    logic                    start_valid_pipeline;
    logic                    start_layering;
    logic                    clear_all;
    logic                    valid_pipeline_busy;
    logic                    layering_busy;
    logic [N_MACS-1:0]       valid_out;
    logic signed [ACC_W-1:0] acc_out_2;
    logic signed [ACC_W-1:0] acc_out_3;
    logic                    res_valid;
    logic                    res_ready;
    logic [2*ACC_W-1:0]      res_data;
    logic                    busy;
    logic                    err;
    logic [1:0]              err_code;

    modport master (
        input  cmd_valid, cmd_count, in_valid, in_data, valid_pipeline_busy,
               layering_busy, valid_out, acc_out_2, acc_out_3, res_ready,
        output cmd_ready, in_ready, a_in, start_valid_pipeline, start_layering,
               clear_all, res_valid, res_data, busy, err, err_code
    );

    modport slave (
        output cmd_valid, cmd_count, in_valid, in_data, valid_pipeline_busy,
               layering_busy, valid_out, acc_out_2, acc_out_3, res_ready,
        input  cmd_ready, in_ready, a_in, start_valid_pipeline, start_layering,
               clear_all, res_valid, res_data, busy, err, err_code
    );
endinterface

// File: rtl/mac_layer_sequencer.sv
// Job-level controller for the 4-MAC top_system datapath. Accepts a job of
// N activations, fires the valid pipeline once per activation, then starts
// layering and returns {acc_out_3, acc_out_2} as a single result beat.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mac_layer_sequencer_if.master (command/activation/result streams,
//          datapath controls and status)
// All outputs are registered from the next-state values.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | cmd_ready high, waiting for a job command
// CLEAR      | clear_all pulse to the datapath
// LOAD       | in_ready high, waiting for the next activation
// FIRE       | start_valid_pipeline pulse once the pipeline is not busy
// WAIT_PIPE  | waiting for a rise of valid_out[1]
// LAYER      | start_layering pulse once layering is not busy
// WAIT_LAYER | capturing acc_out_2/acc_out_3 on rises of valid_out[2]/[3]
// OUTPUT     | res_valid high until res_ready
module mac_layer_sequencer #(
    parameter int ACC_W   = 16,
    parameter int N_MACS  = 4,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    mac_layer_sequencer_if.master bus
);
    localparam int WD_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, CLEAR, LOAD, FIRE, WAIT_PIPE, LAYER, WAIT_LAYER, OUTPUT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [N_MACS-1:0]  vo_q, rise;
    logic [ACC_W-1:0]   a_in_q, a_in_d;
    logic [2*ACC_W-1:0] res_data_q, res_data_d;
    logic               got2_q, got2_d, got3_q, got3_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               svp_q, svp_d, sly_q, sly_d, clr_q, clr_d;
    logic               err_q, err_d, res_valid_q, res_valid_d;
    logic               cmd_ready_q, in_ready_q, busy_q;
    logic               unused_rise;

    function automatic logic watched(state_t s);
        return (s == FIRE) || (s == WAIT_PIPE) || (s == LAYER) || (s == WAIT_LAYER);
    endfunction

    assign rise        = bus.valid_out & ~vo_q;
    assign unused_rise = ^{rise[0], rise[N_MACS-1:3]};

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        a_in_d      = a_in_q;
        res_data_d  = res_data_q;
        got2_d      = got2_q;
        got3_d      = got3_q;
        err_code_d  = err_code_q;
        svp_d       = 1'b0;
        sly_d       = 1'b0;
        clr_d       = 1'b0;
        err_d       = 1'b0;
        res_valid_d = 1'b0;
        wd_d        = '0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    if (bus.cmd_count == '0) begin
                        err_d      = 1'b1;
                        err_code_d = 2'b10;
                    end else begin
                        rem_d      = bus.cmd_count;
                        err_code_d = 2'b00;
                        state_d    = CLEAR;
                        clr_d      = 1'b1;
                    end
                end
            end
            CLEAR: state_d = LOAD;
            LOAD: begin
                if (bus.in_valid && in_ready_q) begin
                    a_in_d  = bus.in_data;
                    state_d = FIRE;
                    // Pulse is registered, so decide on busy at the handshake edge.
                    svp_d   = !bus.valid_pipeline_busy;
                end
            end
            FIRE: begin
                if (svp_q) state_d = WAIT_PIPE;
                else       svp_d   = !bus.valid_pipeline_busy;
            end
            WAIT_PIPE: begin
                if (rise[1]) begin
                    if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
                    if (rem_q <= CNT_W'(1)) begin
                        state_d = LAYER;
                        sly_d   = !bus.layering_busy;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LAYER: begin
                if (sly_q) begin
                    state_d = WAIT_LAYER;
                    got2_d  = 1'b0;
                    got3_d  = 1'b0;
                end else begin
                    sly_d = !bus.layering_busy;
                end
            end
            WAIT_LAYER: begin
                if (rise[2]) begin
                    res_data_d[ACC_W-1:0] = bus.acc_out_2;
                    got2_d                = 1'b1;
                end
                if (rise[3]) begin
                    res_data_d[2*ACC_W-1:ACC_W] = bus.acc_out_3;
                    got3_d                      = 1'b1;
                end
                if (got2_d && got3_d) begin
                    state_d     = OUTPUT;
                    res_valid_d = 1'b1;
                end
            end
            OUTPUT: begin
                if (bus.res_ready) state_d     = IDLE;
                else               res_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // wd_q counts cycles since entry; registered err lands as it reaches TIMEOUT-1.
        if (watched(state_q) && (wd_q == WD_W'(TIMEOUT - 2))) begin
            state_d     = IDLE;
            err_d       = 1'b1;
            err_code_d  = 2'b01;
            clr_d       = 1'b1;
            svp_d       = 1'b0;
            sly_d       = 1'b0;
            res_valid_d = 1'b0;
        end

        if (watched(state_d) && (state_d == state_q)) wd_d = wd_q + WD_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            wd_q        <= '0;
            vo_q        <= '0;
            a_in_q      <= '0;
            res_data_q  <= '0;
            got2_q      <= 1'b0;
            got3_q      <= 1'b0;
            err_code_q  <= 2'b00;
            svp_q       <= 1'b0;
            sly_q       <= 1'b0;
            clr_q       <= 1'b0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            wd_q        <= wd_d;
            vo_q        <= bus.valid_out;
            a_in_q      <= a_in_d;
            res_data_q  <= res_data_d;
            got2_q      <= got2_d;
            got3_q      <= got3_d;
            err_code_q  <= err_code_d;
            svp_q       <= svp_d;
            sly_q       <= sly_d;
            clr_q       <= clr_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            cmd_ready_q <= (state_d == IDLE);
            in_ready_q  <= (state_d == LOAD);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.cmd_ready            = cmd_ready_q;
    assign bus.in_ready             = in_ready_q;
    assign bus.a_in                 = a_in_q;
    assign bus.start_valid_pipeline = svp_q;
    assign bus.start_layering       = sly_q;
    assign bus.clear_all            = clr_q;
    assign bus.res_valid            = res_valid_q;
    assign bus.res_data             = res_data_q;
    assign bus.busy                 = busy_q;
    assign bus.err                  = err_q;
    assign bus.err_code             = err_code_q;
endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Bench for mac_layer_sequencer: directed scenarios plus randomized jobs,
// with a datapath stub (valid_out[1] rises 3 cycles after a pipeline start,
// valid_out[2]/[3] 2 and 3 cycles after a layering start).
module tb_mac_layer_sequencer;
    localparam int ACC_W = 16, N_MACS = 4, CNT_W = 4, TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_layer_sequencer_if #(.ACC_W(ACC_W), .N_MACS(N_MACS), .CNT_W(CNT_W)) bus ();
    mac_layer_sequencer #(.ACC_W(ACC_W), .N_MACS(N_MACS), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_pass = 0;

    // ---------------- datapath stub ----------------
    logic [N_MACS-1:0] stub_vo;
    logic [ACC_W-1:0]  stub_acc2, stub_acc3;
    logic [1:0]        t1, t2, t3;
    logic              stub_dead = 1'b0;
    logic              stub_same = 1'b0;
    logic [ACC_W-1:0]  job_acc2, job_acc3;
    logic [ACC_W-1:0]  job_data [0:15];

    assign bus.valid_out = stub_vo;
    assign bus.acc_out_2 = stub_acc2;
    assign bus.acc_out_3 = stub_acc3;

    always @(posedge clk) begin
        if (rst || bus.clear_all) begin
            stub_vo <= '0; t1 <= 0; t2 <= 0; t3 <= 0;
            stub_acc2 <= '0; stub_acc3 <= '0;
        end else begin
            if (bus.start_valid_pipeline) begin
                stub_vo[1] <= 1'b0;
                t1 <= stub_dead ? 2'd0 : 2'd2;
            end else if (t1 == 2'd1) begin
                stub_vo[1] <= 1'b1; t1 <= 0;
            end else if (t1 != 0) t1 <= t1 - 2'd1;

            if (bus.start_layering) begin
                stub_vo[3:2] <= 2'b00;
                t2 <= 2'd1;
                t3 <= stub_same ? 2'd1 : 2'd2;
                stub_acc2 <= ~job_acc2;
                stub_acc3 <= ~job_acc3;
            end else begin
                if (t2 == 2'd1) begin stub_vo[2] <= 1'b1; stub_acc2 <= job_acc2; t2 <= 0; end
                else if (t2 != 0) t2 <= t2 - 2'd1;
                else if (stub_vo[2]) stub_acc2 <= job_acc2 ^ 16'h5a5a;
                if (t3 == 2'd1) begin stub_vo[3] <= 1'b1; stub_acc3 <= job_acc3; t3 <= 0; end
                else if (t3 != 0) t3 <= t3 - 2'd1;
                else if (stub_vo[3]) stub_acc3 <= job_acc3 ^ 16'ha5a5;
            end
        end
    end

    // ---------------- pulse monitor ----------------
    int clr_cnt = 0, svp_cnt = 0, sly_cnt = 0, err_cnt = 0;
    logic [ACC_W-1:0] ain_log [0:1023];

    always @(negedge clk) begin
        if (bus.clear_all === 1'b1)      clr_cnt <= clr_cnt + 1;
        if (bus.start_layering === 1'b1) sly_cnt <= sly_cnt + 1;
        if (bus.err === 1'b1)            err_cnt <= err_cnt + 1;
        if (bus.start_valid_pipeline === 1'b1) begin
            ain_log[svp_cnt[9:0]] <= bus.a_in;
            svp_cnt <= svp_cnt + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic send_cmd(input logic [CNT_W-1:0] cnt);
        int k;
        k = 0;
        while (bus.cmd_ready !== 1'b1 && k < 100) begin tick(); k++; end
        chk("cmd_ready_wait", 64'(k < 100), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_count = cnt;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_act(input logic [ACC_W-1:0] d);
        int k;
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 100) begin tick(); k++; end
        chk("in_ready_wait", 64'(k < 100), 1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Reference: job_data is the expected a_in sequence, one clear, one
    // layering start, result = {job_acc3, job_acc2} as the stub presented them.
    task automatic run_job(input int count, input int hold, input int busy_hold);
        int k, s_clr, s_svp, s_sly, s_err;
        logic [2*ACC_W-1:0] exp_res;
        s_clr = clr_cnt; s_svp = svp_cnt; s_sly = sly_cnt; s_err = err_cnt;
        exp_res = {job_acc3, job_acc2};
        send_cmd(CNT_W'(count));
        chk("clear_pulse", bus.clear_all, 1);
        chk("busy_up", bus.busy, 1);
        chk("err_code_cleared", bus.err_code, 0);
        tick();
        chk("in_ready_latency", bus.in_ready, 1);
        chk("clear_one_cycle", bus.clear_all, 0);
        for (int i = 0; i < count; i++) begin
            if (i == 0 && busy_hold > 0) bus.valid_pipeline_busy = 1'b1;
            send_act(job_data[i]);
            if (i == 0 && busy_hold > 0) begin
                for (int j = 0; j < busy_hold; j++) begin
                    chk("svp_held_low", bus.start_valid_pipeline, 0);
                    tick();
                end
                bus.valid_pipeline_busy = 1'b0;
                chk("svp_held_low", bus.start_valid_pipeline, 0);
                tick();
            end
            chk("svp_pulse", bus.start_valid_pipeline, 1);
            chk("a_in", {bus.a_in}, job_data[i]);
        end
        k = 0;
        while (bus.res_valid !== 1'b1 && k < 200) begin tick(); k++; end
        chk("res_valid_wait", 64'(k < 200), 1);
        chk("res_data", bus.res_data, exp_res);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("res_hold_valid", bus.res_valid, 1);
            chk("res_hold_data", bus.res_data, exp_res);
            chk("cmd_ready_hold", bus.cmd_ready, 0);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("res_valid_drop", bus.res_valid, 0);
        chk("cmd_ready_back", bus.cmd_ready, 1);
        chk("busy_down", bus.busy, 0);
        chk("clear_count", clr_cnt - s_clr, 1);
        chk("svp_count", svp_cnt - s_svp, count);
        chk("sly_count", sly_cnt - s_sly, 1);
        chk("err_count", err_cnt - s_err, 0);
        for (int i = 0; i < count; i++)
            chk("a_in_at_pulse", ain_log[(s_svp + i) % 1024], job_data[i]);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got no finish, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int k, s_clr, s_svp, cnt;
        bus.cmd_valid = 0; bus.cmd_count = 0; bus.in_valid = 0; bus.in_data = 0;
        bus.valid_pipeline_busy = 0; bus.layering_busy = 0; bus.res_ready = 0;
        job_acc2 = 0; job_acc3 = 0;

        // reset values while rst is high
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_a_in", {bus.a_in}, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_err_code", bus.err_code, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        tick();
        chk("cmd_ready_after_release", bus.cmd_ready, 1);

        // basic two-activation job
        job_data[0] = 16'd10; job_data[1] = 16'd5;
        job_acc2 = 16'd150; job_acc3 = 16'd210; stub_same = 1'b0;
        run_job(2, 0, 0);

        // zero count
        s_clr = clr_cnt; s_svp = svp_cnt;
        send_cmd(0);
        chk("zero_err", bus.err, 1);
        chk("zero_err_code", bus.err_code, 2'b10);
        chk("zero_cmd_ready", bus.cmd_ready, 1);
        chk("zero_no_clear", bus.clear_all, 0);
        tick();
        chk("zero_err_one_cycle", bus.err, 0);
        chk("zero_err_code_hold", bus.err_code, 2'b10);
        repeat (3) tick();
        chk("zero_clear_count", clr_cnt - s_clr, 0);
        chk("zero_svp_count", svp_cnt - s_svp, 0);
        chk("zero_busy", bus.busy, 0);

        // pipeline timeout
        stub_dead = 1'b1;
        send_cmd(1);
        send_act(16'h1234);
        chk("to_svp_pulse", bus.start_valid_pipeline, 1);
        k = 0;
        while (bus.err !== 1'b1 && k < 200) begin tick(); k++; end
        chk("to_latency", k, TIMEOUT);
        chk("to_err_code", bus.err_code, 2'b01);
        chk("to_clear", bus.clear_all, 1);
        chk("to_cmd_ready", bus.cmd_ready, 1);
        chk("to_busy", bus.busy, 0);
        tick();
        chk("to_err_one_cycle", bus.err, 0);
        chk("to_err_code_hold", bus.err_code, 2'b01);
        stub_dead = 1'b0;

        // busy back-pressure on the first activation
        job_data[0] = 16'hfff0; job_data[1] = 16'h0042;
        job_acc2 = 16'h8001; job_acc3 = 16'h7ffe;
        run_job(2, 0, 5);

        // result back-pressure, both layering rises in one cycle
        job_data[0] = 16'h0003; job_data[1] = 16'h8000; job_data[2] = 16'h00ff;
        job_acc2 = 16'hbeef; job_acc3 = 16'hcafe; stub_same = 1'b1;
        run_job(3, 10, 0);
        stub_same = 1'b0;

        // reset in WAIT_PIPE of a 3-activation job
        send_cmd(3);
        send_act(16'h0777);
        chk("mid_svp_pulse", bus.start_valid_pipeline, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_cmd_ready", bus.cmd_ready, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        chk("mid_rst_a_in", {bus.a_in}, 0);
        chk("mid_rst_res_valid", bus.res_valid, 0);
        chk("mid_rst_res_data", bus.res_data, 0);
        chk("mid_rst_err_code", bus.err_code, 0);
        chk("mid_rst_svp", bus.start_valid_pipeline, 0);
        s_clr = clr_cnt; s_svp = svp_cnt;
        tick();
        chk("mid_cmd_ready_release", bus.cmd_ready, 1);
        repeat (6) tick();
        chk("mid_no_clear", clr_cnt - s_clr, 0);
        chk("mid_no_svp", svp_cnt - s_svp, 0);
        job_data[0] = 16'h2468; job_acc2 = 16'h1357; job_acc3 = 16'h9bdf;
        run_job(1, 0, 0);

        // randomized jobs
        for (int j = 0; j < 12; j++) begin
            cnt = $urandom_range(1, 6);
            for (int i = 0; i < cnt; i++) job_data[i] = ACC_W'($urandom);
            job_acc2  = ACC_W'($urandom);
            job_acc3  = ACC_W'($urandom);
            stub_same = 1'($urandom_range(0, 1));
            run_job(cnt, $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mac_layer_sequencer.md
# mac_layer_sequencer

Job-level controller for the 4-MAC `top_system` datapath. It accepts a job command giving the number of activations, then streams each activation onto `a_in`. For each one it pulses `start_valid_pipeline` and waits for MAC1's result. After the last activation it pulses `start_layering`, waits for MAC2 and MAC3, and returns their accumulators as one result beat. It sits between the host/DMA-side streams and `top_system`, and replaces hand-driven start pulses.

## Interface
Parameters:
- `ACC_W`, 16, width of the activation and accumulator values
- `N_MACS`, 4, width of `valid_out`; the block uses bits 1, 2 and 3
- `CNT_W`, 4, width of the job activation count
- `TIMEOUT`, 64, watchdog limit in cycles for any wait state

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `cmd_valid`  in  1  job command valid
- `cmd_ready`  out  1  job command accepted; high only in IDLE
- `cmd_count`  in  CNT_W  number of activations in the job; legal range 1..2^CNT_W-1
- `in_valid`  in  1  activation valid
- `in_ready`  out  1  activation accepted; high only in LOAD
- `in_data`  in  ACC_W signed  activation value
- `a_in`  out  ACC_W signed  registered activation driven to the datapath
- `start_valid_pipeline`  out  1  one-cycle pipeline start pulse
- `start_layering`  out  1  one-cycle layering start pulse
- `clear_all`  out  1  one-cycle datapath clear pulse
- `valid_pipeline_busy`  in  1  datapath pipeline busy
- `layering_busy`  in  1  datapath layering busy
- `valid_out`  in  N_MACS  per-MAC result valid (level)
- `acc_out_2`, `acc_out_3`  in  ACC_W signed  MAC2 and MAC3 accumulators
- `res_valid`  out  1  result beat valid
- `res_ready`  in  1  result beat accepted
- `res_data`  out  2*ACC_W  result beat, `{acc_out_3, acc_out_2}` as captured
- `busy`  out  1  high in every state except IDLE
- `err`  out  1  one-cycle error pulse
- `err_code`  out  2  error cause: 01 = timeout, 10 = count zero; holds the last error until the next accepted command

## Operation
- **Edge detection:** `valid_out` is registered every cycle. A "rise" on bit k means the registered value was 0 and the current value is 1.
- **States:** IDLE, CLEAR, LOAD, FIRE, WAIT_PIPE, LAYER, WAIT_LAYER, OUTPUT.
- **IDLE:**
  - `cmd_ready`=1.
  - On handshake with `cmd_count`=0: `err` pulse, `err_code`=10, stay in IDLE, no datapath pulses.
  - On handshake with `cmd_count`>0: latch `remaining`=`cmd_count`, clear `err_code` to 00, go to CLEAR.
- **CLEAR:** `clear_all`=1 for this one cycle, then go to LOAD.
- **LOAD:**
  - `in_ready`=1.
  - On handshake, register `in_data` into `a_in` and go to FIRE.
  - `a_in` holds its value until the next LOAD handshake.
- **FIRE:**
  - If `valid_pipeline_busy`=0: assert `start_valid_pipeline` for exactly one cycle and go to WAIT_PIPE.
  - Otherwise hold in FIRE with the pulse low.
- **WAIT_PIPE:**
  - On a rise of `valid_out[1]`, decrement `remaining`.
  - Go to LAYER if the result is 0, else go to LOAD.
- **LAYER:**
  - If `layering_busy`=0: assert `start_layering` for one cycle and go to WAIT_LAYER.
  - Otherwise hold.
- **WAIT_LAYER:**
  - On a rise of `valid_out[2]`, capture `acc_out_2`.
  - On a rise of `valid_out[3]`, capture `acc_out_3`.
  - Go to OUTPUT once both captures are done. Both rises in the same cycle are legal.
- **OUTPUT:**
  - `res_valid`=1 with `res_data` held stable until `res_ready`.
  - On the handshake go to IDLE, with no bubble cycle.
- **Watchdog:**
  - A counter clears on entry to FIRE, WAIT_PIPE, LAYER and WAIT_LAYER.
  - It increments every cycle spent in those states.
  - On reaching TIMEOUT-1: `err` pulse, `err_code`=01, `clear_all` pulse in the same cycle, go to IDLE.
  - No watchdog applies in LOAD or OUTPUT, since those wait on the host.
- **Arithmetic:** `remaining` is an unsigned CNT_W-bit counter and never wraps; it is only decremented when it is nonzero. Captured values are stored bit-exact, with no sign extension or truncation.

## Timing
- **Reset values:** state=IDLE, `a_in`=0, `res_data`=0, `remaining`=0, `err_code`=00, and every pulse, valid and busy output 0. `cmd_ready` is 0 while `rst` is high and 1 in the first cycle after release.
- **Reset mid-job:** `rst` sampled high returns the block to IDLE at that edge. No further start or clear pulses are issued and any pending result is dropped.
- **Command to first pulse:** `cmd_valid` accepted at edge 0 → `clear_all` high in cycle 1 → `in_ready` high from cycle 2. An activation accepted at edge n → `start_valid_pipeline` high in cycle n+1 if the pipeline is not busy.
- **Overhead:** rise of `valid_out[1]` → next `in_ready` one cycle later. The final rise → `start_layering` one cycle later if not busy.
- **Output timing:** the last capture → `res_valid` in the next cycle. All outputs are registered.

## Test plan
Benches use a datapath stub in which `valid_out[1]` rises 3 cycles after `start_valid_pipeline`, and `valid_out[2]`/`valid_out[3]` rise 2 and 3 cycles after `start_layering`.
- **Basic two-activation job:** `cmd_count`=2, activations 10 then 5, stub `acc_out_2`=150, `acc_out_3`=210 → exactly one `clear_all`; two `start_valid_pipeline` pulses with `a_in`=10 and then 5; one `start_layering`; `res_data`={210,150}; `busy` returns low.
- **Zero count:** `cmd_count`=0 → `err` pulse, `err_code`=10, no `clear_all` or start pulses, `cmd_ready` stays 1.
- **Pipeline timeout:** stub never raises `valid_out[1]` → `err` with `err_code`=01 exactly TIMEOUT cycles after the `start_valid_pipeline` pulse; `clear_all` in the same cycle; block back in IDLE.
- **Busy back-pressure:** `valid_pipeline_busy` held high 5 cycles after an activation → `start_valid_pipeline` held low; it pulses once in the cycle after busy drops.
- **Result back-pressure:** `res_ready` held low 10 cycles → `res_valid` stays 1 and `res_data` is stable; `cmd_ready` stays 0 until the handshake.
- **Reset mid-job:** `rst` pulsed in WAIT_PIPE of a 3-activation job → all outputs return to reset values; a new `cmd_count`=1 job then completes normally.
